// File: rtl/alu_mdu_if.sv
// Request/response bundle between the EX-stage operand mux and the execute unit.
interface alu_mdu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] oper1;
  logic [XLEN-1:0] oper2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_out;
  logic            busy;

  // Pipeline side: issues ops and consumes results.
  modport master (
    output in_valid, alu_op, oper1, oper2, out_ready,
    input  in_ready, out_valid, alu_out, busy
  );

  // Execute unit side.
  modport slave (
    input  in_valid, alu_op, oper1, oper2, out_ready,
    output in_ready, out_valid, alu_out, busy
  );
endinterface

// File: rtl/alu_mdu.sv
// Execute unit: single-cycle base ALU ops plus iterative radix-2 multiply/divide.
// One op in flight; valid/ready on both sides lets EX stall on long ops.
module alu_mdu #(
  parameter int XLEN          = 32,
  parameter bit DIV_ZERO_FAST = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_mdu_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLT    = 5'd2;
  localparam logic [4:0] OP_SLTU   = 5'd3;
  localparam logic [4:0] OP_SGE    = 5'd4;
  localparam logic [4:0] OP_SGEU   = 5'd5;
  localparam logic [4:0] OP_AND    = 5'd6;
  localparam logic [4:0] OP_OR     = 5'd7;
  localparam logic [4:0] OP_XOR    = 5'd8;
  localparam logic [4:0] OP_SEQ    = 5'd9;
  localparam logic [4:0] OP_SNE    = 5'd10;
  localparam logic [4:0] OP_SL     = 5'd11;
  localparam logic [4:0] OP_SR     = 5'd12;
  localparam logic [4:0] OP_SRA    = 5'd13;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_REM    = 5'd22;

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [4:0]      op_q;
  logic            neg_q;    // negate product / quotient at the end
  logic            rneg_q;   // negate remainder at the end
  logic [XLEN-1:0] acc;      // product high half / partial remainder
  logic [XLEN-1:0] lo;       // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0] opnd;     // multiplicand or divisor magnitude

  logic accept;
  assign bus.in_ready = (state == S_IDLE) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.busy     = (state != S_IDLE);

  // Request decode: op class, operand signedness and magnitudes.
  logic            is_mul, is_div, signed1, signed2, sign1, sign2, div_zero, fast_zero;
  logic [XLEN-1:0] mag1, mag2, zero_res;
  assign is_mul    = (bus.alu_op[4:2] == 3'b100);
  assign is_div    = (bus.alu_op[4:2] == 3'b101);
  assign signed1   = bus.alu_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign signed2   = bus.alu_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  assign sign1     = signed1 && bus.oper1[XLEN-1];
  assign sign2     = signed2 && bus.oper2[XLEN-1];
  assign mag1      = sign1 ? -bus.oper1 : bus.oper1;
  assign mag2      = sign2 ? -bus.oper2 : bus.oper2;
  assign div_zero  = (bus.oper2 == '0);
  assign fast_zero = DIV_ZERO_FAST && is_div && div_zero;
  // Divide by zero: quotient all ones, remainder passes the dividend through.
  assign zero_res  = bus.alu_op[1] ? bus.oper1 : '1;

  logic lt_s, lt_u, eq;
  assign lt_s = $signed(bus.oper1) < $signed(bus.oper2);
  assign lt_u = bus.oper1 < bus.oper2;
  assign eq   = bus.oper1 == bus.oper2;

  // Single-cycle base ALU result; unknown opcodes fall back to ADD.
  logic [XLEN-1:0] base_res;
  always_comb begin
    // NOTE: default assignment first so no path leaves base_res unassigned (no latch).
    base_res = bus.oper1 + bus.oper2;
    case (bus.alu_op)
      OP_SUB:  base_res = bus.oper1 - bus.oper2;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_SGE:  base_res = {{(XLEN-1){1'b0}}, !lt_s};
      OP_SGEU: base_res = {{(XLEN-1){1'b0}}, !lt_u};
      OP_AND:  base_res = bus.oper1 & bus.oper2;
      OP_OR:   base_res = bus.oper1 | bus.oper2;
      OP_XOR:  base_res = bus.oper1 ^ bus.oper2;
      OP_SEQ:  base_res = {{(XLEN-1){1'b0}}, eq};
      OP_SNE:  base_res = {{(XLEN-1){1'b0}}, !eq};
      OP_SL:   base_res = bus.oper1 << bus.oper2[SHW-1:0];
      OP_SR:   base_res = bus.oper1 >> bus.oper2[SHW-1:0];
      OP_SRA:  base_res = $unsigned($signed(bus.oper1) >>> bus.oper2[SHW-1:0]);
      default: base_res = bus.oper1 + bus.oper2;
    endcase
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] acc_nx, lo_nx;
  assign mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc, lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  always_comb begin
    acc_nx = acc;
    lo_nx  = lo;
    if (state == S_MUL) begin
      acc_nx = mul_sum[XLEN:1];
      lo_nx  = {mul_sum[0], lo[XLEN-1:1]};
    end else if (state == S_DIV) begin
      if (!div_diff[XLEN]) begin
        acc_nx = div_diff[XLEN-1:0];
        lo_nx  = {lo[XLEN-2:0], 1'b1};
      end else begin
        acc_nx = div_shift[XLEN-1:0];
        lo_nx  = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up and result select, taken from the final step so it lands on the last edge.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, final_res;
  assign prod   = {acc_nx, lo_nx};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = neg_q ? -lo_nx : lo_nx;
  assign rem    = rneg_q ? -acc_nx : acc_nx;
  always_comb begin
    final_res = op_q[1] ? rem : quo;
    if (state == S_MUL)
      final_res = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here is sequential, so only non-blocking assignments are used.
    if (!rst_n) begin
      state         <= S_IDLE;
      count         <= '0;
      op_q          <= '0;
      neg_q         <= 1'b0;
      rneg_q        <= 1'b0;
      acc           <= '0;
      lo            <= '0;
      opnd          <= '0;
      bus.out_valid <= 1'b0;
      bus.alu_out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= bus.alu_op;
            if (is_mul) begin
              state         <= S_MUL;
              count         <= CW'(XLEN);
              acc           <= '0;
              lo            <= mag2;
              opnd          <= mag1;
              neg_q         <= sign1 ^ sign2;
              bus.out_valid <= 1'b0;
            end else if (is_div && !fast_zero) begin
              state         <= S_DIV;
              count         <= CW'(XLEN);
              acc           <= '0;
              lo            <= mag1;
              opnd          <= mag2;
              // Zero divisor leaves an all-ones magnitude that must stay unsigned.
              neg_q         <= (sign1 ^ sign2) && !div_zero;
              rneg_q        <= sign1;
              bus.out_valid <= 1'b0;
            end else begin
              bus.alu_out   <= is_div ? zero_res : base_res;
              bus.out_valid <= 1'b1;
            end
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
          end
        end
        S_MUL, S_DIV: begin
          acc   <= acc_nx;
          lo    <= lo_nx;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            bus.alu_out   <= final_res;
            bus.out_valid <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
